// File: rtl/cordic_pkg.sv
// Shared constants and types for the circular-mode CORDIC engines.
// Angles are binary angles at 32 bits; narrower datapaths keep the top bits.
package cordic_pkg;

    localparam int LUT_DEPTH = 20;

    // arctan(2^-i) scaled so that a full circle is 2^32
    localparam logic [31:0] ATAN_LUT [LUT_DEPTH] = '{
        32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517
    };

    localparam logic [31:0] ANG_90  = 32'h4000_0000;
    localparam logic [31:0] ANG_M90 = 32'hC000_0000;

    localparam real CORDIC_K = 1.6467602;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        ITER,
        DONE
    } state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctan(2^-i) lookup, truncated to the datapath angle width.
// Indices past the table return zero.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 32
) (
    input  logic [4:0]         idx_i,
    output logic [p_WIDTH-1:0] angle_o
);

    logic [31:0] full_angle;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        full_angle = '0;
        if (idx_i < 5'(LUT_DEPTH)) begin
            full_angle = ATAN_LUT[idx_i];
        end
        angle_o = full_angle[31 -: p_WIDTH];
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: rotates (x, y) onto the x axis and reports
// atan2(y, x) as a binary angle plus the K-scaled magnitude.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int p_WIDTH = 32,
    parameter int p_ITER  = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [p_WIDTH-1:0] o_angle,
    output logic [p_WIDTH+1:0] o_mag
);

    localparam int XW = p_WIDTH + 2;
    localparam logic [p_WIDTH-1:0] Z_90  = ANG_90[31 -: p_WIDTH];
    localparam logic [p_WIDTH-1:0] Z_M90 = ANG_M90[31 -: p_WIDTH];

    state_e                    state_q, state_d;
    logic signed [XW-1:0]      x_q, x_d, y_q, y_d, mag_q, mag_d;
    logic [p_WIDTH-1:0]        z_q, z_d, angle_q, angle_d;
    logic [4:0]                cnt_q, cnt_d;
    logic                      zero_q, zero_d;

    logic [p_WIDTH-1:0]        lut_angle;
    logic signed [XW-1:0]      x_sh, y_sh, x_rot, y_rot;
    logic [p_WIDTH-1:0]        z_rot;

    cordic_atan_lut #(.p_WIDTH(p_WIDTH)) u_atan_lut (
        .idx_i   (cnt_q),
        .angle_o (lut_angle)
    );

    // One micro-rotation; both updates read the pre-update x and y.
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (y_q[XW-1]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - lut_angle;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + lut_angle;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = {{2{i_x[p_WIDTH-1]}}, i_x};
                    y_d     = {{2{i_y[p_WIDTH-1]}}, i_y};
                    zero_d  = (i_x == '0) && (i_y == '0);
                    state_d = PRE;
                end
            end
            PRE: begin
                // Fold the left half-plane into the right so the iterations converge.
                z_d     = '0;
                cnt_d   = '0;
                state_d = ITER;
                if (x_q[XW-1]) begin
                    if (!y_q[XW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = Z_90;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = Z_M90;
                    end
                end
            end
            ITER: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (cnt_q == 5'(p_ITER - 1)) begin
                    // A zero vector never steers y, so its accumulated angle is meaningless.
                    angle_d = zero_q ? '0 : z_rot;
                    mag_d   = x_rot;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_angle = angle_q;
    assign o_mag   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring against a real-arithmetic atan2/hypot model.
module tb_cordic_vectoring;
    import cordic_pkg::*;

    localparam real TWO31 = 2147483648.0;
    localparam real TWO32 = 4294967296.0;
    localparam real PI    = 3.14159265358979323846;
    localparam int  LAT   = 21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_x = '0;
    logic [31:0] i_y = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_angle;
    logic [33:0] o_mag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_vectoring #(.p_WIDTH(32), .p_ITER(20)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x     (i_x),
        .i_y     (i_y),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_angle (o_angle),
        .o_mag   (o_mag)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] angle;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic real to_real(input logic [31:0] v);
        return $itor($signed(v)) / TWO31;
    endfunction

    function automatic real model_mag(input logic [31:0] x, input logic [31:0] y);
        real xr = to_real(x);
        real yr = to_real(y);
        return CORDIC_K * $sqrt(xr * xr + yr * yr);
    endfunction

    function automatic logic [31:0] model_angle(input logic [31:0] x, input logic [31:0] y);
        real    a = $atan2(to_real(y), to_real(x));
        longint t = longint'(a / (2.0 * PI) * TWO32);
        return t[31:0];
    endfunction

    task automatic check_result(input string tag, input logic [31:0] exp_angle, input real exp_mag,
                                input logic [31:0] act_angle, input logic [33:0] act_mag);
        int     d   = int'(act_angle - exp_angle);
        longint li  = longint'($signed(act_mag));
        real    am  = real'(li) / TWO31;
        real    err = (am > exp_mag) ? am - exp_mag : exp_mag - am;
        check({tag, " angle"}, (d >= -4096) && (d <= 4096), longint'(act_angle), longint'(exp_angle));
        check({tag, " mag"}, err <= 2.0e-6 * exp_mag + 64.0 / TWO31, li, longint'(exp_mag * TWO31));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where o_valid is seen.
    task automatic run_vec(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] ang, output logic [33:0] mag, output int lat);
        i_x     = x;
        i_y     = y;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ang = o_angle;
        mag = o_mag;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ang, x, y, exp_a;
        logic [33:0] mag;
        int          lat;
        bit          stable;

        #12;
        check("reset ready", o_ready == 1'b1, longint'(o_ready), 1);
        check("reset valid", o_valid == 1'b0, longint'(o_valid), 0);
        check("reset angle", o_angle == '0, longint'(o_angle), 0);
        check("reset mag", o_mag == '0, longint'(o_mag), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{x: 32'h4000_0000, y: 32'h0000_0000, angle: 32'h0000_0000};
        vecs[1] = '{x: 32'h4000_0000, y: 32'h4000_0000, angle: 32'h2000_0000};
        vecs[2] = '{x: 32'hC000_0000, y: 32'h0000_0000, angle: 32'h8000_0000};
        vecs[3] = '{x: 32'h0000_0000, y: 32'hC000_0000, angle: 32'hC000_0000};
        vecs[4] = '{x: 32'hC000_0000, y: 32'h4000_0000, angle: 32'h6000_0000};
        vecs[5] = '{x: 32'hC000_0000, y: 32'hC000_0000, angle: 32'hA000_0000};
        vecs[6] = '{x: 32'h8000_0000, y: 32'h0000_0000, angle: 32'h8000_0000};
        vecs[7] = '{x: 32'h0000_0000, y: 32'h0000_0000, angle: 32'h0000_0000};
        vecs[8] = '{x: 32'h0000_0000, y: 32'h4000_0000, angle: 32'h4000_0000};
        vecs[9] = '{x: 32'h7FFF_FFFF, y: 32'h7FFF_FFFF, angle: 32'h2000_0000};

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i].x, vecs[i].y, ang, mag, lat);
            check($sformatf("vec%0d latency", i), lat == LAT, longint'(lat), longint'(LAT));
            check_result($sformatf("vec%0d", i), vecs[i].angle, model_mag(vecs[i].x, vecs[i].y), ang, mag);
            consume();
            check($sformatf("vec%0d back to idle", i), o_ready && !o_valid,
                  longint'({o_ready, o_valid}), 2);
        end

        // Backpressure: result held, new requests ignored while DONE.
        x = 32'h3000_0000;
        y = 32'h1000_0000;
        run_vec(x, y, ang, mag, lat);
        check_result("bp", model_angle(x, y), model_mag(x, y), ang, mag);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid = ~i_valid;
            i_x     = $urandom;
            i_y     = $urandom;
            @(negedge clk);
            if (!o_valid || o_ready || o_angle != ang || o_mag != mag) stable = 1'b0;
        end
        i_valid = 1'b0;
        check("bp hold stable", stable, longint'(o_angle), longint'(ang));
        consume();
        check("bp release", o_ready && !o_valid, longint'({o_ready, o_valid}), 2);

        // Reset in the middle of the iterations.
        i_x     = 32'h2000_0000;
        i_y     = 32'hE000_0000;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst valid", o_valid == 1'b0, longint'(o_valid), 0);
        check("midrst ready", o_ready == 1'b1, longint'(o_ready), 1);
        check("midrst angle", o_angle == '0, longint'(o_angle), 0);
        check("midrst mag", o_mag == '0, longint'(o_mag), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        x = 32'hD000_0000;
        y = 32'h2800_0000;
        run_vec(x, y, ang, mag, lat);
        check("postrst latency", lat == LAT, longint'(lat), longint'(LAT));
        check_result("postrst", model_angle(x, y), model_mag(x, y), ang, mag);
        consume();

        // Random vectors with magnitude well above the quantisation floor.
        for (int i = 0; i < 40; i++) begin
            do begin
                x = $urandom;
                y = $urandom;
            end while ((to_real(x) < 0.125 && to_real(x) > -0.125) &&
                       (to_real(y) < 0.125 && to_real(y) > -0.125));
            run_vec(x, y, ang, mag, lat);
            exp_a = model_angle(x, y);
            check($sformatf("rnd%0d latency", i), lat == LAT, longint'(lat), longint'(LAT));
            check_result($sformatf("rnd%0d", i), exp_a, model_mag(x, y), ang, mag);
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
